field_op_sequencer: RTL and testbench
=====================================

Name: field_op_sequencer

Overview:
Parametrised, start/done-handshaked control sequencer for the GF(2^m) field datapath. It issues the ALU control group, mux selects, ROM select, RAM base/offset addresses and write enables for multiplication, squaring, addition and a new repeated-squaring mode (tau^k Frobenius maps). Word count is a parameter. It sits between the point-arithmetic controller and the field ALU/register-file RAM.

Parameters:
NUM_WORDS, 5, field-element length in RAM words (W); legal range 2..31
RD_OFS_W, 5, rd_offset width; must satisfy 2^RD_OFS_W > W
WT_OFS_W, 6, wt_offset width
CNT_W, 8, repeated-squaring count width
BASE_W, 3, RAM base-select width

Ports:
clk  in  1  system clock, rising edge
rst  in  1  synchronous reset, active-low
start  in  1  single-cycle request; sampled only in IDLE
mode  in  2  0=mul, 1=square, 2=add, 3=repeated square
sqr_count  in  CNT_W  number of squarings for mode 3; latched at start
base_src  in  BASE_W  RAM base of source operand(s); latched at start
base_dst  in  BASE_W  RAM base of result; latched at start
alu_ctrl  out  9  {en1,en2,clr1,clr2,sel3,sel6,mask,Cen,Cshift}
sel4  out  1  adder-input select (high in add XOR phase)
sel5  out  1  squarer-path select (high in SQ phase)
rom_sel  out  3  reduction-constant select
wea  out  1  RAM write enable
base_sel  out  BASE_W  current RAM base
rd_offset  out  RD_OFS_W  read word index
wt_offset  out  WT_OFS_W  write word index
offset_sel  out  1  1 = write-address path active
busy  out  1  high from the cycle after start acceptance through the DONE cycle
done  out  1  one-cycle pulse in DONE state
state  out  4  current state encoding (debug)

Behaviour:
- Clock clk; reset synchronous and active-low: rst=0 at a rising edge forces IDLE, clears word counter i and pass counter, all outputs 0. Applies mid-operation; no partial write completes after the reset edge.
- All outputs registered (Moore): valid in the cycle the state is occupied.
- IDLE: start=1 latches mode, sqr_count, base_src, base_dst; next state per mode. start while busy ignored.
- States: IDLE, CLR, MAC, SQ, RED, WR, LDA, XORW, DONE.
- mul (mode 0): CLR 1 cycle (clr1=clr2=1) -> MAC W cycles (en1=1, Cen=1, Cshift=1, rd_offset=W-1-i, base_sel=base_src) -> RED 2 cycles (mask=1, sel3=1, rom_sel=1 then 2) -> WR W cycles (wea=1, offset_sel=1, wt_offset=i, base_sel=base_dst) -> DONE.
- square (mode 1): as mul with SQ replacing MAC: en2=1, sel6=1, sel5=1, rd_offset=i.
- add (mode 2): LDA W cycles (en1=1, rd_offset=i, base_src) -> XORW W cycles (en2=1, sel4=1, wea=1, offset_sel=1, rd_offset=wt_offset=i, base_sel alternates base_src+1 read / base_dst write by offset_sel) -> DONE.
- repeated square (mode 3): square pass (CLR,SQ,RED,WR) repeated sqr_count times; pass 0 reads base_src, later passes read base_dst (in place; SQ reads all W words before WR writes). sqr_count=0: IDLE -> DONE directly, no wea.
- Latency, start sampled at edge k: mul/square done at cycle k+2W+4; add at k+2W+1; mode 3 at k+n(2W+3)+1.
- DONE: 1 cycle, done=1, busy=1, then IDLE; start in DONE ignored.
- i counts 0..W-1 per phase, resets to 0 on every phase change; pass counter CNT_W bits, no wrap (sqr_count max 2^CNT_W-1).
- Unused outputs 0 in each state; IDLE drives all outputs 0.

Decomposition:
- Package field_seq_pkg: state enum, mode constants, alu_ctrl bit-index constants, ROM select constants.
- One sub-module: seq_word_counter (W-bounded counter with clear/enable and terminal-count flag), instantiated for i; pass counter inline.

Test Plan:
- W=5, mode 0, start at k -> CLR k+1, MAC k+2..k+6 rd_offset 4,3,2,1,0, RED rom_sel 1,2, wea k+9..k+13 wt_offset 0..4 on base_dst, done k+14.
- W=5, mode 2, base_src=2, base_dst=5 -> 5 LDA cycles, wea k+6..k+10 with base_sel=5 when offset_sel=1, done k+11.
- W=5, mode 3, sqr_count=3 -> 15 wea cycles, pass 0 reads base_src, passes 1-2 read base_dst, done k+40.
- mode 3, sqr_count=0 -> done at k+1, wea never asserted, busy high 1 cycle.
- start re-pulsed during MAC and in DONE -> ignored; exactly one done; next start from IDLE accepted.
- rst=0 during WR of mul -> next cycle IDLE, all outputs 0, no further wea; fresh mul then completes with done at k+14.

Source files
------------

// File: rtl/field_seq_pkg.sv
// Shared types and constants for the GF(2^m) field-operation sequencer:
// state encoding, operation modes, ALU control bit positions, ROM selects.
package field_seq_pkg;

    typedef enum logic [3:0] {
        S_IDLE = 4'd0,
        S_CLR  = 4'd1,
        S_MAC  = 4'd2,
        S_SQ   = 4'd3,
        S_RED  = 4'd4,
        S_WR   = 4'd5,
        S_LDA  = 4'd6,
        S_XORW = 4'd7,
        S_DONE = 4'd8
    } state_e;

    localparam logic [1:0] MODE_MUL = 2'd0;
    localparam logic [1:0] MODE_SQR = 2'd1;
    localparam logic [1:0] MODE_ADD = 2'd2;
    localparam logic [1:0] MODE_RSQ = 2'd3;

    // alu_ctrl = {en1,en2,clr1,clr2,sel3,sel6,mask,Cen,Cshift}
    localparam int ALU_EN1    = 8;
    localparam int ALU_EN2    = 7;
    localparam int ALU_CLR1   = 6;
    localparam int ALU_CLR2   = 5;
    localparam int ALU_SEL3   = 4;
    localparam int ALU_SEL6   = 3;
    localparam int ALU_MASK   = 2;
    localparam int ALU_CEN    = 1;
    localparam int ALU_CSHIFT = 0;

    localparam logic [2:0] ROM_NONE   = 3'd0;
    localparam logic [2:0] ROM_RED_LO = 3'd1;
    localparam logic [2:0] ROM_RED_HI = 3'd2;

    typedef struct packed {
        logic [8:0] alu;
        logic       sel4;
        logic       sel5;
        logic [2:0] rom;
        logic       wea;
        logic       osel;
        logic       busy;
        logic       done;
    } ctrl_t;

endpackage

// File: rtl/seq_word_counter.sv
// Word index counter bounded to 0..NUM_WORDS-1. Exposes both the current and
// the next value so the owner can register outputs for the upcoming cycle.
module seq_word_counter #(
    parameter int NUM_WORDS = 5,
    parameter int CW        = 5
) (
    input  logic          clk_i,
    input  logic          rst_n_i,
    input  logic          clr_i,
    input  logic          en_i,
    output logic [CW-1:0] cnt_o,
    output logic [CW-1:0] nxt_o,
    output logic          tc_o
);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    assign tc_o  = (cnt_q == CW'(NUM_WORDS - 1));
    assign cnt_o = cnt_q;
    assign nxt_o = cnt_d;

    // Next count: clear wins, otherwise step and wrap at the terminal word.
    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (en_i) begin
            if (tc_o) begin
                cnt_d = '0;
            end else begin
                cnt_d = cnt_q + CW'(1);
            end
        end else begin
            cnt_d = cnt_q;
        end
    end

    // Count register with synchronous active-low reset.
    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/field_op_sequencer.sv
// Control sequencer for the field ALU and register-file RAM: multiply, square,
// add and repeated squaring, with all control outputs registered (Moore).
module field_op_sequencer
    import field_seq_pkg::*;
#(
    parameter int NUM_WORDS = 5,
    parameter int RD_OFS_W  = 5,
    parameter int WT_OFS_W  = 6,
    parameter int CNT_W     = 8,
    parameter int BASE_W    = 3
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic [1:0]          mode,
    input  logic [CNT_W-1:0]    sqr_count,
    input  logic [BASE_W-1:0]   base_src,
    input  logic [BASE_W-1:0]   base_dst,
    output logic [8:0]          alu_ctrl,
    output logic                sel4,
    output logic                sel5,
    output logic [2:0]          rom_sel,
    output logic                wea,
    output logic [BASE_W-1:0]   base_sel,
    output logic [RD_OFS_W-1:0] rd_offset,
    output logic [WT_OFS_W-1:0] wt_offset,
    output logic                offset_sel,
    output logic                busy,
    output logic                done,
    output logic [3:0]          state
);

    localparam int IW = RD_OFS_W;

    state_e              state_q, state_d;
    logic [1:0]          mode_q, mode_d;
    logic [CNT_W-1:0]    sqr_q, sqr_d;
    logic [CNT_W-1:0]    pass_q, pass_d;
    logic [BASE_W-1:0]   bsrc_q, bsrc_d;
    logic [BASE_W-1:0]   bdst_q, bdst_d;
    logic [IW-1:0]       i_q, i_d;
    logic                i_tc;
    logic                i_clr;
    logic                i_en;
    logic [BASE_W-1:0]   rd_base_s;

    ctrl_t               ctrl_q, ctrl_d;
    logic [BASE_W-1:0]   base_sel_q, base_sel_d;
    logic [RD_OFS_W-1:0] rd_q, rd_d;
    logic [WT_OFS_W-1:0] wt_q, wt_d;

    assign i_clr = (state_d != state_q);
    assign i_en  = (state_q != S_IDLE);

    seq_word_counter #(
        .NUM_WORDS (NUM_WORDS),
        .CW        (IW)
    ) u_word_cnt (
        .clk_i   (clk),
        .rst_n_i (rst),
        .clr_i   (i_clr),
        .en_i    (i_en),
        .cnt_o   (i_q),
        .nxt_o   (i_d),
        .tc_o    (i_tc)
    );

    // Later repeated-squaring passes work in place on the destination.
    assign rd_base_s = ((mode_d == MODE_RSQ) && (pass_d != '0)) ? bdst_d : bsrc_d;

    // Next state, operand latching and pass counting.
    always_comb begin
        state_d = state_q;
        mode_d  = mode_q;
        sqr_d   = sqr_q;
        pass_d  = pass_q;
        bsrc_d  = bsrc_q;
        bdst_d  = bdst_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    mode_d = mode;
                    sqr_d  = sqr_count;
                    bsrc_d = base_src;
                    bdst_d = base_dst;
                    pass_d = '0;
                    case (mode)
                        MODE_ADD: state_d = S_LDA;
                        MODE_RSQ: state_d = (sqr_count == '0) ? S_DONE : S_CLR;
                        default:  state_d = S_CLR;
                    endcase
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_CLR:  state_d = (mode_q == MODE_MUL) ? S_MAC : S_SQ;
            S_MAC:  state_d = i_tc ? S_RED : S_MAC;
            S_SQ:   state_d = i_tc ? S_RED : S_SQ;
            S_RED:  state_d = (i_q == IW'(1)) ? S_WR : S_RED;
            S_WR: begin
                if (!i_tc) begin
                    state_d = S_WR;
                end else if ((mode_q == MODE_RSQ) && ((pass_q + CNT_W'(1)) != sqr_q)) begin
                    state_d = S_CLR;
                    pass_d  = pass_q + CNT_W'(1);
                end else begin
                    state_d = S_DONE;
                end
            end
            S_LDA:  state_d = i_tc ? S_XORW : S_LDA;
            S_XORW: state_d = i_tc ? S_DONE : S_XORW;
            S_DONE: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Output decode for the state about to be entered.
    always_comb begin
        ctrl_d      = '0;
        base_sel_d  = '0;
        rd_d        = '0;
        wt_d        = '0;
        ctrl_d.busy = (state_d != S_IDLE);
        case (state_d)
            S_IDLE: ctrl_d = '0;
            S_CLR: begin
                ctrl_d.alu[ALU_CLR1] = 1'b1;
                ctrl_d.alu[ALU_CLR2] = 1'b1;
            end
            S_MAC: begin
                ctrl_d.alu[ALU_EN1]    = 1'b1;
                ctrl_d.alu[ALU_CEN]    = 1'b1;
                ctrl_d.alu[ALU_CSHIFT] = 1'b1;
                rd_d       = RD_OFS_W'(NUM_WORDS - 1) - i_d;
                base_sel_d = rd_base_s;
            end
            S_SQ: begin
                ctrl_d.alu[ALU_EN2]  = 1'b1;
                ctrl_d.alu[ALU_SEL6] = 1'b1;
                ctrl_d.sel5          = 1'b1;
                rd_d       = i_d;
                base_sel_d = rd_base_s;
            end
            S_RED: begin
                ctrl_d.alu[ALU_MASK] = 1'b1;
                ctrl_d.alu[ALU_SEL3] = 1'b1;
                ctrl_d.rom = (i_d == '0) ? ROM_RED_LO : ROM_RED_HI;
            end
            S_WR: begin
                ctrl_d.wea  = 1'b1;
                ctrl_d.osel = 1'b1;
                wt_d        = WT_OFS_W'(i_d);
                base_sel_d  = bdst_d;
            end
            S_LDA: begin
                ctrl_d.alu[ALU_EN1] = 1'b1;
                rd_d       = i_d;
                base_sel_d = bsrc_d;
            end
            S_XORW: begin
                ctrl_d.alu[ALU_EN2] = 1'b1;
                ctrl_d.sel4 = 1'b1;
                ctrl_d.wea  = 1'b1;
                ctrl_d.osel = 1'b1;
                rd_d        = i_d;
                wt_d        = WT_OFS_W'(i_d);
                base_sel_d  = bdst_d;
            end
            S_DONE: ctrl_d.done = 1'b1;
            default: ctrl_d = '0;
        endcase
    end

    // FSM state, latched operands and registered outputs.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q    <= S_IDLE;
            mode_q     <= '0;
            sqr_q      <= '0;
            pass_q     <= '0;
            bsrc_q     <= '0;
            bdst_q     <= '0;
            ctrl_q     <= '0;
            base_sel_q <= '0;
            rd_q       <= '0;
            wt_q       <= '0;
        end else begin
            state_q    <= state_d;
            mode_q     <= mode_d;
            sqr_q      <= sqr_d;
            pass_q     <= pass_d;
            bsrc_q     <= bsrc_d;
            bdst_q     <= bdst_d;
            ctrl_q     <= ctrl_d;
            base_sel_q <= base_sel_d;
            rd_q       <= rd_d;
            wt_q       <= wt_d;
        end
    end

    assign alu_ctrl   = ctrl_q.alu;
    assign sel4       = ctrl_q.sel4;
    assign sel5       = ctrl_q.sel5;
    assign rom_sel    = ctrl_q.rom;
    assign wea        = ctrl_q.wea;
    assign offset_sel = ctrl_q.osel;
    assign busy       = ctrl_q.busy;
    assign done       = ctrl_q.done;
    assign base_sel   = base_sel_q;
    assign rd_offset  = rd_q;
    assign wt_offset  = wt_q;
    assign state      = state_q;

endmodule

// File: tb/tb_field_op_sequencer.sv
// Scoreboard bench: each accepted operation is expanded into its expected
// per-cycle output trace; a negedge monitor pops and compares while busy.
module tb_field_op_sequencer;

    localparam int W = 5;

    localparam int PH_CLR  = 0;
    localparam int PH_MAC  = 1;
    localparam int PH_SQ   = 2;
    localparam int PH_RED  = 3;
    localparam int PH_WR   = 4;
    localparam int PH_LDA  = 5;
    localparam int PH_XOR  = 6;
    localparam int PH_DONE = 7;

    typedef struct {
        int         cyc;
        logic [8:0] alu;
        logic       sel4;
        logic       sel5;
        logic [2:0] rom;
        logic       wea;
        logic [2:0] base;
        logic [4:0] rd;
        logic [5:0] wt;
        logic       osel;
        logic       done;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic [1:0] mode;
    logic [7:0] sqr_count;
    logic [2:0] base_src;
    logic [2:0] base_dst;
    logic [8:0] alu_ctrl;
    logic       sel4, sel5, wea, offset_sel, busy, done;
    logic [2:0] rom_sel;
    logic [2:0] base_sel;
    logic [4:0] rd_offset;
    logic [5:0] wt_offset;
    logic [3:0] state;

    int   tests = 0;
    int   fails = 0;
    int   edges = 0;
    int   gc    = 0;
    exp_t q[$];

    field_op_sequencer #(
        .NUM_WORDS (W), .RD_OFS_W (5), .WT_OFS_W (6), .CNT_W (8), .BASE_W (3)
    ) dut (
        .clk (clk), .rst (rst), .start (start), .mode (mode),
        .sqr_count (sqr_count), .base_src (base_src), .base_dst (base_dst),
        .alu_ctrl (alu_ctrl), .sel4 (sel4), .sel5 (sel5), .rom_sel (rom_sel),
        .wea (wea), .base_sel (base_sel), .rd_offset (rd_offset),
        .wt_offset (wt_offset), .offset_sel (offset_sel), .busy (busy),
        .done (done), .state (state)
    );

    always #5 clk = ~clk;

    always @(posedge clk) edges <= edges + 1;

    function automatic exp_t mk(int c, int ph, int i, logic [2:0] b);
        exp_t e;
        e.cyc = c; e.alu = '0; e.sel4 = 1'b0; e.sel5 = 1'b0; e.rom = '0;
        e.wea = 1'b0; e.base = '0; e.rd = '0; e.wt = '0; e.osel = 1'b0; e.done = 1'b0;
        case (ph)
            PH_CLR: e.alu = 9'b001100000;
            PH_MAC: begin e.alu = 9'b100000011; e.rd = 5'(W - 1 - i); e.base = b; end
            PH_SQ:  begin e.alu = 9'b010001000; e.sel5 = 1'b1; e.rd = 5'(i); e.base = b; end
            PH_RED: begin e.alu = 9'b000010100; e.rom = 3'(i + 1); end
            PH_WR:  begin e.wea = 1'b1; e.osel = 1'b1; e.wt = 6'(i); e.base = b; end
            PH_LDA: begin e.alu = 9'b100000000; e.rd = 5'(i); e.base = b; end
            PH_XOR: begin
                e.alu = 9'b010000000; e.sel4 = 1'b1; e.wea = 1'b1; e.osel = 1'b1;
                e.rd = 5'(i); e.wt = 6'(i); e.base = b;
            end
            default: e.done = 1'b1;
        endcase
        return e;
    endfunction

    task automatic push(int ph, int i, logic [2:0] b);
        q.push_back(mk(gc, ph, i, b));
        gc++;
    endtask

    task automatic phase(int ph, int len, logic [2:0] b);
        for (int i = 0; i < len; i++) push(ph, i, b);
    endtask

    // Reference trace for one operation accepted at edge k.
    task automatic gen(int md, int n, logic [2:0] bs, logic [2:0] bd, int k);
        gc = k + 1;
        case (md)
            0, 1: begin
                push(PH_CLR, 0, 3'd0);
                phase((md == 0) ? PH_MAC : PH_SQ, W, bs);
                phase(PH_RED, 2, 3'd0);
                phase(PH_WR, W, bd);
            end
            2: begin
                phase(PH_LDA, W, bs);
                phase(PH_XOR, W, bd);
            end
            default: begin
                for (int p = 0; p < n; p++) begin
                    push(PH_CLR, 0, 3'd0);
                    phase(PH_SQ, W, (p == 0) ? bs : bd);
                    phase(PH_RED, 2, 3'd0);
                    phase(PH_WR, W, bd);
                end
            end
        endcase
        push(PH_DONE, 0, 3'd0);
    endtask

    // Monitor: compare every busy cycle against the scoreboard, idle cycles against zero.
    always @(negedge clk) begin
        int   cur;
        exp_t e;
        cur = edges + 1;
        if (rst === 1'b1) begin
            tests++;
            if (busy === 1'b1) begin
                if (q.size() == 0) begin
                    fails++;
                    $display("FAIL unexpected_busy cyc=%0d: got busy=1 state=%0d, required no activity", cur, state);
                end else begin
                    e = q.pop_front();
                    if (e.cyc != cur || alu_ctrl !== e.alu || sel4 !== e.sel4 || sel5 !== e.sel5 ||
                        rom_sel !== e.rom || wea !== e.wea || base_sel !== e.base ||
                        rd_offset !== e.rd || wt_offset !== e.wt || offset_sel !== e.osel ||
                        done !== e.done) begin
                        fails++;
                        $display("FAIL trace: got cyc=%0d alu=%b s4=%b s5=%b rom=%0d wea=%b base=%0d rd=%0d wt=%0d osel=%b done=%b; required cyc=%0d alu=%b s4=%b s5=%b rom=%0d wea=%b base=%0d rd=%0d wt=%0d osel=%b done=%b",
                                 cur, alu_ctrl, sel4, sel5, rom_sel, wea, base_sel, rd_offset, wt_offset, offset_sel, done,
                                 e.cyc, e.alu, e.sel4, e.sel5, e.rom, e.wea, e.base, e.rd, e.wt, e.osel, e.done);
                    end
                end
            end else begin
                if ({alu_ctrl, sel4, sel5, rom_sel, wea, base_sel, rd_offset, wt_offset, offset_sel, done, state} !== '0) begin
                    fails++;
                    $display("FAIL idle_outputs cyc=%0d: got alu=%b wea=%b done=%b state=%0d base=%0d rd=%0d wt=%0d, required all 0",
                             cur, alu_ctrl, wea, done, state, base_sel, rd_offset, wt_offset);
                end else if (q.size() != 0 && q[0].cyc < cur) begin
                    fails++;
                    $display("FAIL missing_cycle cyc=%0d: got busy=0, required activity for cyc %0d", cur, q[0].cyc);
                    void'(q.pop_front());
                end
            end
        end
    end

    task automatic wait_idle();
        int n = 0;
        while ((busy !== 1'b0 || q.size() != 0) && n < 5000) begin
            @(negedge clk);
            n++;
        end
        if (n >= 5000) begin
            tests++;
            fails++;
            $display("FAIL idle_timeout: got busy=%b pending=%0d, required idle within 5000 cycles", busy, q.size());
            q.delete();
        end
    endtask

    task automatic launch(int md, int n, logic [2:0] bs, logic [2:0] bd);
        wait_idle();
        @(negedge clk);
        #1;
        start = 1'b1; mode = 2'(md); sqr_count = 8'(n); base_src = bs; base_dst = bd;
        @(posedge clk);
        #1;
        start = 1'b0;
        mode = 2'($urandom); sqr_count = 8'($urandom); base_src = 3'($urandom); base_dst = 3'($urandom);
        gen(md, n, bs, bd, edges);
    endtask

    task automatic wait_sig(input int which, output bit ok);
        int n = 0;
        ok = 1'b0;
        while (n < 200 && !ok) begin
            @(negedge clk);
            n++;
            ok = (which == 0) ? (wea === 1'b1) : (done === 1'b1);
        end
        if (!ok) begin
            tests++;
            fails++;
            $display("FAIL wait_%s: got no event in 200 cycles, required one", (which == 0) ? "wea" : "done");
        end
    endtask

    initial begin
        bit ok;
        rst = 1'b0; start = 1'b0; mode = '0; sqr_count = '0; base_src = '0; base_dst = '0;
        repeat (3) @(posedge clk);
        #1;
        tests++;
        if ({alu_ctrl, sel4, sel5, rom_sel, wea, base_sel, rd_offset, wt_offset, offset_sel, busy, done, state} !== '0) begin
            fails++;
            $display("FAIL reset_state: got busy=%b state=%0d alu=%b, required all 0", busy, state, alu_ctrl);
        end
        rst = 1'b1;

        launch(0, 0, 3'd1, 3'd6);
        launch(2, 0, 3'd2, 3'd5);
        launch(1, 0, 3'd3, 3'd4);
        launch(3, 3, 3'd1, 3'd7);
        launch(3, 0, 3'd2, 3'd3);
        launch(3, 1, 3'd4, 3'd0);

        // Starts during MAC and during DONE must be ignored.
        launch(0, 0, 3'd5, 3'd2);
        repeat (3) @(negedge clk);
        #1;
        start = 1'b1; mode = 2'd3; sqr_count = 8'd200;
        @(posedge clk);
        #1;
        start = 1'b0;
        wait_sig(1, ok);
        #1;
        start = 1'b1; mode = 2'd0;
        @(posedge clk);
        #1;
        start = 1'b0;
        launch(2, 0, 3'd6, 3'd1);

        // Reset in the middle of a write phase.
        launch(0, 0, 3'd1, 3'd2);
        wait_sig(0, ok);
        repeat (2) @(negedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b1;
        q.delete();
        tests++;
        if (busy !== 1'b0 || wea !== 1'b0 || state !== 4'd0 || done !== 1'b0) begin
            fails++;
            $display("FAIL reset_mid_wr: got busy=%b wea=%b state=%0d done=%b, required 0 0 0 0", busy, wea, state, done);
        end
        launch(0, 0, 3'd3, 3'd6);

        for (int t = 0; t < 40; t++) begin
            launch(int'($urandom_range(0, 3)), int'($urandom_range(0, 6)),
                   3'($urandom), 3'($urandom));
            if ($urandom_range(0, 1) == 1) repeat ($urandom_range(1, 3)) @(negedge clk);
        end
        launch(3, 255, 3'd0, 3'd7);

        wait_idle();
        repeat (3) @(negedge clk);
        tests++;
        if (q.size() != 0) begin
            fails++;
            $display("FAIL leftover: got %0d pending entries, required 0", q.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
